// File: rtl/i2c_slave.sv
// rtl/i2c_slave.sv - single-address I2C target with oversampled SCL/SDA and split SDA lines.
// Optional general-call (8'h00) address match: define I2C_SLAVE_GENERAL_CALL_EN.
`timescale 1ns/1ps
module i2c_slave #(
    parameter logic [6:0] SLAVE_ADDR = 7'b1010101
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       scl,
    input  logic       sda_output_m,
    output logic       sda_output_s,
    input  logic [7:0] tx_data,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       tx_req,
    output logic       rw,
    output logic       busy
);

    typedef enum logic [2:0] {
        IDLE, ADDR, ADDR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK, IGNORE
    } state_t;

    state_t     state;
    logic       scl_s1, scl_s2, scl_d;
    logic       sda_s1, sda_s2, sda_d;
    logic [7:0] shift;
    logic [2:0] bit_cnt;
    logic       ack_drv;

    logic       scl_rise, scl_fall, start_det, stop_det;
    logic       addr_hit, gc_hit;
    logic [7:0] shift_in;

    // Sync flops reset high (idle bus) so leaving reset never fakes a START.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            scl_s1 <= 1'b1;
            scl_s2 <= 1'b1;
            scl_d  <= 1'b1;
            sda_s1 <= 1'b1;
            sda_s2 <= 1'b1;
            sda_d  <= 1'b1;
        end else begin
            scl_s1 <= scl;
            scl_s2 <= scl_s1;
            scl_d  <= scl_s2;
            sda_s1 <= sda_output_m;
            sda_s2 <= sda_s1;
            sda_d  <= sda_s2;
        end
    end

    assign scl_rise  = scl_s2 & ~scl_d;
    assign scl_fall  = ~scl_s2 & scl_d;
    assign start_det = ~sda_s2 & sda_d & scl_s2;
    assign stop_det  = sda_s2 & ~sda_d & scl_s2;
    assign shift_in  = {shift[6:0], sda_s2};
    assign addr_hit  = (shift_in[7:1] == SLAVE_ADDR);
`ifdef I2C_SLAVE_GENERAL_CALL_EN
    assign gc_hit    = (shift_in == 8'h00);
`else
    assign gc_hit    = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            sda_output_s <= 1'b1;
            rx_data      <= 8'h00;
            rx_valid     <= 1'b0;
            tx_req       <= 1'b0;
            rw           <= 1'b0;
            busy         <= 1'b0;
            shift        <= 8'h00;
            bit_cnt      <= 3'd0;
            ack_drv      <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            tx_req   <= 1'b0;
            if (stop_det) begin
                state        <= IDLE;
                sda_output_s <= 1'b1;
                busy         <= 1'b0;
            end else if (start_det) begin
                state        <= ADDR;
                sda_output_s <= 1'b1;
                busy         <= 1'b0;
                bit_cnt      <= 3'd0;
                shift        <= 8'h00;
            end else begin
                case (state)
                    IDLE: sda_output_s <= 1'b1;
                    ADDR: begin
                        if (scl_rise) begin
                            shift <= shift_in;
                            if (bit_cnt == 3'd7) begin
                                bit_cnt <= 3'd0;
                                ack_drv <= 1'b0;
                                if (addr_hit) begin
                                    state <= ADDR_ACK;
                                    rw    <= sda_s2;
                                    busy  <= 1'b1;
                                end else if (gc_hit) begin
                                    state <= ADDR_ACK;
                                    rw    <= 1'b0;
                                    busy  <= 1'b1;
                                end else begin
                                    state <= IGNORE;
                                end
                            end else begin
                                bit_cnt <= bit_cnt + 3'd1;
                            end
                        end
                    end
                    // First fall drives the ACK low; the second ends the ACK bit.
                    ADDR_ACK: begin
                        if (scl_fall) begin
                            if (!ack_drv) begin
                                ack_drv      <= 1'b1;
                                sda_output_s <= 1'b0;
                                tx_req       <= rw;
                            end else begin
                                bit_cnt <= 3'd0;
                                if (rw) begin
                                    shift        <= tx_data;
                                    sda_output_s <= tx_data[7];
                                    state        <= RD_DATA;
                                end else begin
                                    sda_output_s <= 1'b1;
                                    state        <= WR_DATA;
                                end
                            end
                        end
                    end
                    WR_DATA: begin
                        if (scl_rise) begin
                            shift <= shift_in;
                            if (bit_cnt == 3'd7) begin
                                rx_data  <= shift_in;
                                rx_valid <= 1'b1;
                                ack_drv  <= 1'b0;
                                bit_cnt  <= 3'd0;
                                state    <= WR_ACK;
                            end else begin
                                bit_cnt <= bit_cnt + 3'd1;
                            end
                        end
                    end
                    WR_ACK: begin
                        if (scl_fall) begin
                            if (!ack_drv) begin
                                ack_drv      <= 1'b1;
                                sda_output_s <= 1'b0;
                            end else begin
                                sda_output_s <= 1'b1;
                                bit_cnt      <= 3'd0;
                                state        <= WR_DATA;
                            end
                        end
                    end
                    // bit_cnt counts bits already put on the bus after bit 7.
                    RD_DATA: begin
                        if (scl_fall) begin
                            if (bit_cnt == 3'd7) begin
                                sda_output_s <= 1'b1;
                                tx_req       <= 1'b1;
                                bit_cnt      <= 3'd0;
                                state        <= RD_ACK;
                            end else begin
                                sda_output_s <= shift[6];
                                shift        <= {shift[6:0], 1'b0};
                                bit_cnt      <= bit_cnt + 3'd1;
                            end
                        end
                    end
                    RD_ACK: begin
                        if (scl_rise && sda_s2) begin
                            state <= IGNORE;
                            busy  <= 1'b0;
                        end else if (scl_fall) begin
                            shift        <= tx_data;
                            sda_output_s <= tx_data[7];
                            bit_cnt      <= 3'd0;
                            state        <= RD_DATA;
                        end
                    end
                    IGNORE:  sda_output_s <= 1'b1;
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule
